counter_run_ctrl: RTL and testbench

Keypad-driven run controller for the two-digit BCD ping-pong counter. It collects a two-digit start value from keypad key events, range-checks it, and issues a one-cycle load to the counter. It then sequences run, pause and clear, and generates the counter's single-cycle count-enable tick from the system clock, using a slow or fast prescale selected by the speed switch. It sits between the keypad scanner and the counter and replaces the derived-clock selection in the top level, so the counter runs on clk with an enable.

---
 rtl/counter_run_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_counter_run_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/counter_run_ctrl.sv
// Keypad-driven run controller for the BCD ping-pong counter.
// Collects a start value, loads it, then paces the counter with a tick.
module counter_run_ctrl #(
    parameter int FAST_DIV = 22,
    parameter int SLOW_DIV = 24,
    parameter int MAX_VAL  = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       speed,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       cnt_tick,
    output logic       cnt_load,
    output logic [3:0] load_bcd1,
    output logic [3:0] load_bcd0,
    output logic [3:0] entry_bcd1,
    output logic [3:0] entry_bcd0,
    output logic       running,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_LOAD   = 3'd2,
        S_RUN    = 3'd3,
        S_PAUSED = 3'd4
    } state_t;

    localparam logic [3:0] K_START = 4'hA;
    localparam logic [3:0] K_PAUSE = 4'hB;
    localparam logic [3:0] K_CLEAR = 4'hC;

    localparam logic [SLOW_DIV-1:0] SLOW_T = '1;
    localparam logic [SLOW_DIV-1:0] FAST_T = SLOW_T >> (SLOW_DIV - FAST_DIV);
    localparam logic [SLOW_DIV-1:0] P_ONE  = {{(SLOW_DIV-1){1'b0}}, 1'b1};
    localparam logic [7:0]          MAX_V  = 8'(MAX_VAL);

    state_t              r_state;
    logic [SLOW_DIV-1:0] r_presc;
    logic [3:0]          r_ent1;
    logic [3:0]          r_ent0;
    logic [3:0]          r_ld1;
    logic [3:0]          r_ld0;
    logic [1:0]          r_cnt;
    logic                r_tick;
    logic                r_load;
    logic                r_run;
    logic                r_err;

    logic                w_key;
    logic                w_digit;
    logic                w_start;
    logic                w_pause;
    logic                w_clear;
    logic [SLOW_DIV-1:0] w_term;
    logic                w_at_term;
    logic [7:0]          w_val;

    // Key decode, tick terminal and entered value
    always_comb begin
        w_key     = key_valid && (key_code <= K_CLEAR);
        w_digit   = key_valid && (key_code <= 4'd9);
        w_start   = key_valid && (key_code == K_START);
        w_pause   = key_valid && (key_code == K_PAUSE);
        w_clear   = key_valid && (key_code == K_CLEAR);
        w_term    = speed ? FAST_T : SLOW_T;
        w_at_term = (r_presc >= w_term);
        w_val     = ({4'd0, r_ent1} * 8'd10) + {4'd0, r_ent0};
    end

    // Control FSM with registered strobes, entry buffer and prescaler
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_ent1  <= 4'd0;
            r_ent0  <= 4'd0;
            r_ld1   <= 4'd0;
            r_ld0   <= 4'd0;
            r_cnt   <= 2'd0;
            r_tick  <= 1'b0;
            r_load  <= 1'b0;
            r_run   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_load <= 1'b0;
            if (w_key && (r_state != S_LOAD)) r_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_digit) begin
                        r_state <= S_ENTRY;
                        r_ent1  <= 4'd0;
                        r_ent0  <= key_code;
                        r_cnt   <= 2'd1;
                    end else if (w_start) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                        r_presc <= '0;
                    end else if (w_clear) begin
                        r_ent1 <= 4'd0;
                        r_ent0 <= 4'd0;
                    end
                end
                S_ENTRY: begin
                    if (w_digit) begin
                        if (r_cnt == 2'd1) begin
                            r_ent1 <= r_ent0;
                            r_ent0 <= key_code;
                            r_cnt  <= 2'd2;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (w_start) begin
                        if (w_val > MAX_V) begin
                            r_err   <= 1'b1;
                            r_ent1  <= 4'd0;
                            r_ent0  <= 4'd0;
                            r_cnt   <= 2'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_LOAD;
                            r_load  <= 1'b1;
                            r_ld1   <= r_ent1;
                            r_ld0   <= r_ent0;
                        end
                    end else if (w_clear) begin
                        r_ent1  <= 4'd0;
                        r_ent0  <= 4'd0;
                        r_cnt   <= 2'd0;
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                    r_run   <= 1'b1;
                    r_presc <= '0;
                    r_ent1  <= 4'd0;
                    r_ent0  <= 4'd0;
                    r_cnt   <= 2'd0;
                end
                S_RUN: begin
                    if (w_pause) begin
                        r_state <= S_PAUSED;
                        r_run   <= 1'b0;
                    end else if (w_clear) begin
                        r_state <= S_IDLE;
                        r_run   <= 1'b0;
                        r_presc <= '0;
                    end else if (w_at_term) begin
                        r_tick  <= 1'b1;
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + P_ONE;
                    end
                end
                S_PAUSED: begin
                    if (w_start) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                    end else if (w_clear) begin
                        r_state <= S_IDLE;
                        r_presc <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_run   <= 1'b0;
                    r_presc <= '0;
                end
            endcase
        end
    end

    assign cnt_tick   = r_tick;
    assign cnt_load   = r_load;
    assign load_bcd1  = r_ld1;
    assign load_bcd0  = r_ld0;
    assign entry_bcd1 = r_ent1;
    assign entry_bcd0 = r_ent0;
    assign running    = r_run;
    assign err        = r_err;
    assign state      = r_state;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl.
// Two builds share stimulus: MAX_VAL=99 (a_*) and MAX_VAL=60 (b_*).
module tb_counter_run_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       speed = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;

    logic       a_tick, a_load, a_run, a_err;
    logic [3:0] a_ld1, a_ld0, a_e1, a_e0;
    logic [2:0] a_state;
    logic       b_tick, b_load, b_run, b_err;
    logic [3:0] b_ld1, b_ld0, b_e1, b_e0;
    logic [2:0] b_state;

    int n_run = 0;
    int n_fail = 0;
    int cyc;
    int nt;

    counter_run_ctrl #(.FAST_DIV(2), .SLOW_DIV(4), .MAX_VAL(99)) u_a (
        .clk(clk), .reset(reset), .speed(speed),
        .key_valid(key_valid), .key_code(key_code),
        .cnt_tick(a_tick), .cnt_load(a_load),
        .load_bcd1(a_ld1), .load_bcd0(a_ld0),
        .entry_bcd1(a_e1), .entry_bcd0(a_e0),
        .running(a_run), .err(a_err), .state(a_state)
    );

    counter_run_ctrl #(.FAST_DIV(2), .SLOW_DIV(4), .MAX_VAL(60)) u_b (
        .clk(clk), .reset(reset), .speed(speed),
        .key_valid(key_valid), .key_code(key_code),
        .cnt_tick(b_tick), .cnt_load(b_load),
        .load_bcd1(b_ld1), .load_bcd0(b_ld0),
        .entry_bcd1(b_e1), .entry_bcd0(b_e0),
        .running(b_run), .err(b_err), .state(b_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic key(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_tick && n < 100);
    endtask

    function automatic logic [31:0] pack_a();
        return {a_tick, a_load, a_ld1, a_ld0, a_e1, a_e0,
                a_run, a_err, a_state};
    endfunction

    function automatic logic [31:0] pack_b();
        return {b_tick, b_load, b_ld1, b_ld0, b_e1, b_e0,
                b_run, b_err, b_state};
    endfunction

    initial begin
        #12;
        check("rst_a_all", pack_a(), 32'd0);
        check("rst_b_all", pack_b(), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // range check on the 60 build
        key(4'd7);
        key(4'd5);
        key(4'hA);
        check("b75_err", b_err, 1);
        check("b75_state", b_state, 0);
        check("b75_entry", {b_e1, b_e0}, 8'h00);
        check("b75_noload", b_load, 0);
        check("a75_load", {a_load, a_ld1, a_ld0}, 9'h175);
        key(4'd3);
        check("b3_err", b_err, 0);
        check("b3_entry", {b_e1, b_e0}, 8'h03);
        key(4'hC);
        check("clr_state", {a_state, b_state}, 6'o00);
        key(4'd6);
        key(4'd0);
        key(4'hA);
        check("b60_load", {b_load, b_ld1, b_ld0, b_err}, 10'b1_0110_0000_0);
        key(4'hC);
        key(4'd6);
        key(4'd1);
        key(4'hA);
        check("b61_rej", {b_err, b_load, b_state}, 5'b1_0_000);
        check("a61_load", {a_load, a_ld1, a_ld0}, 9'h161);
        key(4'hC);
        check("clr2", {a_state, b_state, b_err}, 7'd0);

        // load 42 and tick at the slow rate
        key(4'd4);
        check("e04", {a_e1, a_e0, a_state}, 11'b0000_0100_001);
        key(4'd2);
        check("e42", {a_e1, a_e0}, 8'h42);
        key(4'hA);
        check("ld42", {a_load, a_ld1, a_ld0, a_state}, 12'b1_0100_0010_010);
        @(negedge clk);
        check("run1", {a_load, a_run, a_state, a_e1, a_e0}, 13'b0_1_011_00000000);
        check("ld_hold", {a_ld1, a_ld0}, 8'h42);
        wait_tick(cyc);
        check("tick1_slow", cyc, 16);
        wait_tick(cyc);
        check("tick2_slow", cyc, 16);

        // slow to fast switch with prescaler past the fast terminal
        repeat (9) @(negedge clk);
        speed = 1'b1;
        wait_tick(cyc);
        check("sw_fast", cyc, 1);
        wait_tick(cyc);
        check("fast_per", cyc, 4);
        speed = 1'b0;

        // pause at prescaler 6, resume from the held value
        repeat (5) @(negedge clk);
        key(4'hB);
        check("paused", {a_state, a_run}, 4'b100_0);
        nt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_tick) nt++;
        end
        check("pause_ticks", nt, 0);
        key(4'hA);
        wait_tick(cyc);
        check("resume_tick", cyc, 10);

        // overflow digit, clear, start without load
        key(4'hC);
        check("run_clr", {a_state, a_run}, 4'b000_0);
        key(4'd1);
        key(4'd2);
        key(4'd3);
        check("e123", {a_e1, a_e0, a_err}, 9'b0001_0010_1);
        key(4'hC);
        check("e_clr", {a_state, a_e1, a_e0, a_err}, 12'd0);
        key(4'hA);
        check("st_noload", {a_state, a_load, a_run}, 5'b011_0_1);
        key(4'hE);
        check("ign_E", a_state, 3);

        // asynchronous reset between edges mid-RUN
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", pack_a(), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        key(4'hA);
        check("rst_run", a_state, 3);
        wait_tick(cyc);
        check("rst_tick", cyc, 16);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
